// File: rtl/dtlb_refill_pkg.sv
// rtl/dtlb_refill_pkg.sv - shared address, PTE and walker-state types for the data TLB refill path
// Purpose: address-space widths, virtual/physical pointer types, the PTE layout,
//          the walker state encoding and the PTE address helper.
// Ports:   none (package).
package dtlb_refill_pkg;

  localparam int VPN_W  = 20;
  localparam int PPN_W  = 8;
  localparam int OFF_W  = 12;
  localparam int VPTR_W = VPN_W + OFF_W;
  localparam int PPTR_W = PPN_W + OFF_W;

  typedef logic [VPN_W-1:0]  vpn_t;
  typedef logic [PPN_W-1:0]  ppn_t;
  typedef logic [PPTR_W-1:0] pptr_t;

  typedef struct packed {
    vpn_t             vpn;
    logic [OFF_W-1:0] offset;
  } vaddr_fields_t;

  typedef union packed {
    logic [VPTR_W-1:0] raw;
    vaddr_fields_t     fields;
  } vptr_t;

  // 32-bit page-table entry: valid flag on top, PPN in the low bits.
  typedef struct packed {
    logic             valid;
    logic [30-PPN_W:0] reserved;
    ppn_t             ppn;
  } pte_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_FILL  = 3'd2,
    ST_FAULT = 3'd3,
    ST_HOLD  = 3'd4
  } refill_state_t;

  // Flat table, one 4-byte PTE per VPN; the sum wraps at the physical width.
  function automatic pptr_t pte_addr(input pptr_t base, input vpn_t vpn);
    logic [VPN_W+1:0] byte_off;
    byte_off = {vpn, 2'b00};
    return base + byte_off[PPTR_W-1:0];
  endfunction

endpackage

// File: rtl/dtlb_refill_if.sv
// rtl/dtlb_refill_if.sv - PTE read bus between the TLB refill walker and the memory arbiter
// Purpose: groups the PTE read request/acknowledge signals.
// Ports:   mem_req/mem_addr (walker -> arbiter), mem_ack/mem_rdata (arbiter -> walker).
interface dtlb_refill_if;
  import dtlb_refill_pkg::*;

  logic        mem_req;
  pptr_t       mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/dtlb_refill.sv
// rtl/dtlb_refill.sv - data TLB miss handler: fetches the PTE and refills the TLB
// Purpose: on a user-mode miss, reads PTE at ptbr + 4*vpn, then strobes a TLB
//          write on a valid PTE or pulses fault on an invalid PTE / timeout.
// Ports:   clk, rst (sync, active-low); miss, mode, vaddr, ptbr from the TLB;
//          mem (master side of the PTE read bus); write_en/write_vpn/write_ppn
//          refill port; busy, fault, fault_vpn status.
module dtlb_refill
  import dtlb_refill_pkg::*;
#(
  parameter int TIMEOUT  = 64,
  parameter int HOLD_CYC = 2,
  parameter int PTE_V    = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 miss,
  input  logic                 mode,
  input  vptr_t                vaddr,
  input  pptr_t                ptbr,
  dtlb_refill_if.master        mem,
  output logic                 write_en,
  output vpn_t                 write_vpn,
  output ppn_t                 write_ppn,
  output logic                 busy,
  output logic                 fault,
  output vpn_t                 fault_vpn
);

  localparam logic [2:0] S_IDLE  = 3'(ST_IDLE);
  localparam logic [2:0] S_REQ   = 3'(ST_REQ);
  localparam logic [2:0] S_FILL  = 3'(ST_FILL);
  localparam logic [2:0] S_FAULT = 3'(ST_FAULT);
  localparam logic [2:0] S_HOLD  = 3'(ST_HOLD);

  localparam int CNT_W = $clog2(TIMEOUT + HOLD_CYC + 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  vpn_t             vpn;

  // Page offset and the PTE reserved field never influence the walk.
  logic unused_bits;
  assign unused_bits = ^{vaddr.fields.offset, mem.mem_rdata[31:PPN_W]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      vpn          <= '0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      write_en     <= 1'b0;
      write_vpn    <= '0;
      write_ppn    <= '0;
      busy         <= 1'b0;
      fault        <= 1'b0;
      fault_vpn    <= '0;
    end else begin
      // Strobes default low so each is exactly one cycle wide.
      write_en <= 1'b0;
      fault    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (miss && !mode) begin
            vpn          <= vaddr.fields.vpn;
            mem.mem_addr <= pte_addr(ptbr, vaddr.fields.vpn);
            mem.mem_req  <= 1'b1;
            cnt          <= '0;
            busy         <= 1'b1;
            state        <= S_REQ;
          end
        end
        S_REQ: begin
          cnt <= cnt + 1'b1;
          // An ack in the final timeout cycle still completes the walk.
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            if (mem.mem_rdata[PTE_V]) begin
              write_en  <= 1'b1;
              write_vpn <= vpn;
              write_ppn <= mem.mem_rdata[PPN_W-1:0];
              state     <= S_FILL;
            end else begin
              fault     <= 1'b1;
              fault_vpn <= vpn;
              state     <= S_FAULT;
            end
          end else if (cnt == TO_LAST) begin
            mem.mem_req <= 1'b0;
            fault       <= 1'b1;
            fault_vpn   <= vpn;
            state       <= S_FAULT;
          end
        end
        S_FILL, S_FAULT: begin
          cnt   <= '0;
          state <= S_HOLD;
        end
        S_HOLD: begin
          // Gives the TLB time to re-look-up before a held miss can retrigger.
          if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          mem.mem_req <= 1'b0;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtlb_refill.sv
// tb/tb_dtlb_refill.sv - directed self-checking bench for dtlb_refill
module tb_dtlb_refill;
  import dtlb_refill_pkg::*;

  logic  clk;
  logic  rst;
  logic  miss;
  logic  mode;
  vptr_t vaddr;
  pptr_t ptbr;
  logic  write_en;
  vpn_t  write_vpn;
  ppn_t  write_ppn;
  logic  busy;
  logic  fault;
  vpn_t  fault_vpn;

  int checks;
  int errors;

  dtlb_refill_if mem_bus();

  dtlb_refill dut (
    .clk       (clk),
    .rst       (rst),
    .miss      (miss),
    .mode      (mode),
    .vaddr     (vaddr),
    .ptbr      (ptbr),
    .mem       (mem_bus),
    .write_en  (write_en),
    .write_vpn (write_vpn),
    .write_ppn (write_ppn),
    .busy      (busy),
    .fault     (fault),
    .fault_vpn (fault_vpn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_walk(input pptr_t base, input vpn_t v);
    ptbr                = base;
    vaddr.fields.vpn    = v;
    vaddr.fields.offset = 12'h5A4;
    mode                = 1'b0;
    miss                = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    miss = 1'b0;
    mode = 1'b0;
    vaddr.raw = '0;
    ptbr = '0;
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = '0;
    tick();
    tick();
    checks++;
    if (mem_bus.mem_req !== 1'b0 || mem_bus.mem_addr !== 20'h0) begin
      $display("FAIL reset_mem: req=%b addr=%h expected 0/00000", mem_bus.mem_req, mem_bus.mem_addr);
      errors++;
    end
    checks++;
    if (write_en !== 1'b0 || write_vpn !== 20'h0 || write_ppn !== 8'h0) begin
      $display("FAIL reset_write: en=%b vpn=%h ppn=%h expected 0", write_en, write_vpn, write_ppn);
      errors++;
    end
    checks++;
    if (busy !== 1'b0 || fault !== 1'b0 || fault_vpn !== 20'h0) begin
      $display("FAIL reset_status: busy=%b fault=%b fault_vpn=%h expected 0", busy, fault, fault_vpn);
      errors++;
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_refill();
    start_walk(20'h10000, 20'h00012);
    checks++;
    if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 20'h10048 || busy !== 1'b1) begin
      $display("FAIL refill_req: req=%b addr=%h busy=%b expected 1/10048/1", mem_bus.mem_req, mem_bus.mem_addr, busy);
      errors++;
    end
    // Inputs changed mid-walk must not disturb the latched request.
    miss = 1'b0;
    ptbr = 20'h20000;
    vaddr.fields.vpn = 20'h00777;
    tick();
    tick();
    checks++;
    if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 20'h10048) begin
      $display("FAIL refill_stable: req=%b addr=%h expected 1/10048", mem_bus.mem_req, mem_bus.mem_addr);
      errors++;
    end
    mem_bus.mem_ack = 1'b1;
    mem_bus.mem_rdata = 32'h8000_0005;
    tick();
    mem_bus.mem_ack = 1'b0;
    checks++;
    if (write_en !== 1'b1 || write_vpn !== 20'h00012 || write_ppn !== 8'h05 || mem_bus.mem_req !== 1'b0) begin
      $display("FAIL refill_write: en=%b vpn=%h ppn=%h req=%b expected 1/00012/05/0", write_en, write_vpn, write_ppn, mem_bus.mem_req);
      errors++;
    end
    tick();
    checks++;
    if (write_en !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL refill_pulse: en=%b busy=%b expected 0/1", write_en, busy);
      errors++;
    end
    tick();
    checks++;
    if (busy !== 1'b1) begin
      $display("FAIL refill_hold: busy=%b expected 1", busy);
      errors++;
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL refill_idle: busy=%b expected 0", busy);
      errors++;
    end
  endtask

  task automatic test_invalid_pte();
    logic we_seen;
    we_seen = 1'b0;
    start_walk(20'h10000, 20'h00012);
    miss = 1'b0;
    we_seen |= write_en;
    mem_bus.mem_ack = 1'b1;
    mem_bus.mem_rdata = 32'h0000_0005;
    tick();
    mem_bus.mem_ack = 1'b0;
    we_seen |= write_en;
    checks++;
    if (fault !== 1'b1 || fault_vpn !== 20'h00012) begin
      $display("FAIL invalid_fault: fault=%b fault_vpn=%h expected 1/00012", fault, fault_vpn);
      errors++;
    end
    tick();
    we_seen |= write_en;
    checks++;
    if (fault !== 1'b0 || fault_vpn !== 20'h00012) begin
      $display("FAIL invalid_pulse: fault=%b fault_vpn=%h expected 0/00012", fault, fault_vpn);
      errors++;
    end
    tick();
    we_seen |= write_en;
    tick();
    we_seen |= write_en;
    checks++;
    if (we_seen !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL invalid_nowrite: write_en_seen=%b busy=%b expected 0/0", we_seen, busy);
      errors++;
    end
  endtask

  task automatic test_timeout();
    int high_cnt;
    high_cnt = 0;
    start_walk(20'h10000, 20'h00ABC);
    miss = 1'b0;
    while (mem_bus.mem_req === 1'b1 && high_cnt < 200) begin
      high_cnt++;
      tick();
    end
    checks++;
    if (high_cnt != 64) begin
      $display("FAIL timeout_len: mem_req high %0d cycles expected 64", high_cnt);
      errors++;
    end
    checks++;
    if (fault !== 1'b1 || fault_vpn !== 20'h00ABC) begin
      $display("FAIL timeout_fault: fault=%b fault_vpn=%h expected 1/00abc", fault, fault_vpn);
      errors++;
    end
    tick();
    tick();
    checks++;
    if (fault !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL timeout_hold: fault=%b busy=%b expected 0/1", fault, busy);
      errors++;
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL timeout_idle: busy=%b expected 0", busy);
      errors++;
    end
  endtask

  task automatic test_supervisor();
    logic any_act;
    any_act = 1'b0;
    ptbr = 20'h10000;
    vaddr.fields.vpn = 20'h00012;
    mode = 1'b1;
    miss = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      any_act |= mem_bus.mem_req | busy;
    end
    checks++;
    if (any_act !== 1'b0) begin
      $display("FAIL supervisor_ignore: req_or_busy_seen=%b expected 0", any_act);
      errors++;
    end
    miss = 1'b0;
    mode = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_walk();
    start_walk(20'h10000, 20'h00012);
    miss = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (mem_bus.mem_req !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL midreset_drop: req=%b busy=%b expected 0/0", mem_bus.mem_req, busy);
      errors++;
    end
    mem_bus.mem_ack = 1'b1;
    mem_bus.mem_rdata = 32'h8000_0033;
    tick();
    mem_bus.mem_ack = 1'b0;
    checks++;
    if (write_en !== 1'b0 || fault !== 1'b0) begin
      $display("FAIL midreset_lateack: write_en=%b fault=%b expected 0/0", write_en, fault);
      errors++;
    end
    start_walk(20'h10000, 20'h00012);
    miss = 1'b0;
    checks++;
    if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 20'h10048) begin
      $display("FAIL midreset_restart: req=%b addr=%h expected 1/10048", mem_bus.mem_req, mem_bus.mem_addr);
      errors++;
    end
    mem_bus.mem_ack = 1'b1;
    mem_bus.mem_rdata = 32'h8000_0033;
    tick();
    mem_bus.mem_ack = 1'b0;
    checks++;
    if (write_en !== 1'b1 || write_ppn !== 8'h33) begin
      $display("FAIL midreset_refill: write_en=%b ppn=%h expected 1/33", write_en, write_ppn);
      errors++;
    end
    tick();
    tick();
    tick();
  endtask

  task automatic test_wrap_single_walk();
    int   rises;
    int   waited;
    logic prev_req;
    rises = 0;
    waited = 0;
    prev_req = mem_bus.mem_req;
    start_walk(20'hFFFF0, 20'h00008);
    if (mem_bus.mem_req && !prev_req) rises++;
    prev_req = mem_bus.mem_req;
    checks++;
    if (mem_bus.mem_addr !== 20'h00010) begin
      $display("FAIL wrap_addr: addr=%h expected 00010", mem_bus.mem_addr);
      errors++;
    end
    mem_bus.mem_ack = 1'b1;
    mem_bus.mem_rdata = 32'h8000_00AA;
    tick();
    mem_bus.mem_ack = 1'b0;
    checks++;
    if (write_en !== 1'b1 || write_vpn !== 20'h00008 || write_ppn !== 8'hAA) begin
      $display("FAIL wrap_write: en=%b vpn=%h ppn=%h expected 1/00008/aa", write_en, write_vpn, write_ppn);
      errors++;
    end
    // Miss stays asserted through the hold window, as a stalled TLB would.
    while (busy === 1'b1 && waited < 20) begin
      tick();
      waited++;
      if (mem_bus.mem_req && !prev_req) rises++;
      prev_req = mem_bus.mem_req;
    end
    miss = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL wrap_busy_timeout: busy=%b after %0d cycles expected 0", busy, waited);
      errors++;
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_bus.mem_req && !prev_req) rises++;
      prev_req = mem_bus.mem_req;
    end
    checks++;
    if (rises != 1) begin
      $display("FAIL wrap_single_walk: walks=%0d expected 1", rises);
      errors++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_refill();
    test_invalid_pte();
    test_timeout();
    test_supervisor();
    test_reset_mid_walk();
    test_wrap_single_walk();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
